// File: rtl/instr_fetch_if.sv
// Memory read bus between the fetch unit and instruction memory.
// master: fetch unit (drives mem_rd/mem_addr), slave: memory (drives mem_ack/mem_rdata).
interface instr_fetch_if;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: 8-bit PC, single outstanding memory read, STOP halt,
// jump handling, read timeout. Ports: clk, rst (async active-low),
// controller side (fetch_req, jump_en/jump_addr, instr/instr_valid/instr_ready,
// pc, pc_wrap, halted, mem_err) and memory bus via instr_fetch_if.master.
module instr_fetch #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_req,
    input  logic                 jump_en,
    input  logic [7:0]           jump_addr,
    instr_fetch_if.master        mem,
    output logic [7:0]           instr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [7:0]           pc,
    output logic                 pc_wrap,
    output logic                 halted,
    output logic                 mem_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_VALID = 3'd2;
    localparam logic [2:0] S_HALT  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [2:0] state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_vld_q, pend_vld_d;
    logic [7:0] pend_addr_q, pend_addr_d;
    logic       pc_wrap_q, pc_wrap_d;

    logic [7:0] cnt_inc;
    logic       is_stop;

    assign cnt_inc = cnt_q + 8'd1;
    assign is_stop = (instr_q[7:5] == 3'b100);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        pc_wrap_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d      = 8'd0;
                pend_vld_d = 1'b0;
                if (jump_en) begin
                    pc_d = jump_addr;
                end else if (fetch_req) begin
                    state_d = S_READ;
                end
            end

            S_READ: begin
                if (mem.mem_ack) begin
                    cnt_d      = 8'd0;
                    pend_vld_d = 1'b0;
                    // A jump seen during the read redirects the PC and
                    // drops the returned data; a same-cycle jump wins
                    // over an older pending one.
                    if (jump_en) begin
                        pc_d    = jump_addr;
                        state_d = S_IDLE;
                    end else if (pend_vld_q) begin
                        pc_d    = pend_addr_q;
                        state_d = S_IDLE;
                    end else begin
                        instr_d   = mem.mem_rdata;
                        pc_d      = pc_q + 8'd1;
                        pc_wrap_d = (pc_q == 8'hFF);
                        state_d   = S_VALID;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (jump_en) begin
                        pend_vld_d  = 1'b1;
                        pend_addr_d = jump_addr;
                    end
                    if (cnt_inc == TIMEOUT_CNT) begin
                        state_d = S_ERR;
                    end
                end
            end

            S_VALID: begin
                // The delivered instruction stays valid across a jump.
                if (jump_en) begin
                    pc_d = jump_addr;
                end
                if (instr_ready) begin
                    state_d = is_stop ? S_HALT : S_IDLE;
                end
            end

            S_HALT: begin
                if (jump_en) begin
                    pc_d    = jump_addr;
                    state_d = S_IDLE;
                end
            end

            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= 8'h00;
            cnt_q       <= 8'd0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= 8'h00;
            pc_wrap_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            cnt_q       <= cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            pc_wrap_q   <= pc_wrap_d;
        end
    end

    // Status outputs decode straight from state so reset clears them
    // without waiting for a clock.
    assign mem.mem_rd   = (state_q == S_READ);
    assign mem.mem_addr = pc_q;
    assign instr        = instr_q;
    assign instr_valid  = (state_q == S_VALID);
    assign pc           = pc_q;
    assign pc_wrap      = pc_wrap_q;
    assign halted       = (state_q == S_HALT);
    assign mem_err      = (state_q == S_ERR);

endmodule
